// File: rtl/tap_pkg.sv
// Shared TAP definitions: state encoding, instruction opcodes and the strobe bundle.
package tap_pkg;

   localparam int unsigned IR_WIDTH_DEF = 4;
   localparam int unsigned STATE_W      = 4;

   typedef enum logic [STATE_W-1:0] {
      ST_EX2_DR = 4'h0,
      ST_EX1_DR = 4'h1,
      ST_SH_DR  = 4'h2,
      ST_PA_DR  = 4'h3,
      ST_SEL_IR = 4'h4,
      ST_UPD_DR = 4'h5,
      ST_CAP_DR = 4'h6,
      ST_SEL_DR = 4'h7,
      ST_EX2_IR = 4'h8,
      ST_EX1_IR = 4'h9,
      ST_SH_IR  = 4'hA,
      ST_PA_IR  = 4'hB,
      ST_RTI    = 4'hC,
      ST_UPD_IR = 4'hD,
      ST_CAP_IR = 4'hE,
      ST_TLR    = 4'hF
   } tap_state_e;

   localparam logic [IR_WIDTH_DEF-1:0] OP_SAMPLE   = 4'h1;
   localparam logic [IR_WIDTH_DEF-1:0] OP_EXTEST   = 4'h2;
   localparam logic [IR_WIDTH_DEF-1:0] OP_INTEST   = 4'h3;
   localparam logic [IR_WIDTH_DEF-1:0] OP_RUNBIST  = 4'h4;
   localparam logic [IR_WIDTH_DEF-1:0] OP_IDCODE   = 4'h7;
   localparam logic [IR_WIDTH_DEF-1:0] OP_USERCODE = 4'h8;
   localparam logic [IR_WIDTH_DEF-1:0] OP_BYPASS   = 4'hF;

   typedef struct packed {
      logic tlr;
      logic cap_dr;
      logic sh_dr;
      logic upd_dr;
      logic cap_ir;
      logic sh_ir;
      logic upd_ir;
   } tap_strobe_t;

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP state machine driven by TMS, plus combinational per-state strobes.
module tap_fsm
   import tap_pkg::*;
(
   input  logic        TCK,
   input  logic        TRST,
   input  logic        TMS,
   output tap_state_e  state_q,
   output tap_strobe_t strobe_c
);

   tap_state_e state_d;

   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) state_q <= ST_TLR;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_TLR:    state_d = TMS ? ST_TLR    : ST_RTI;
         ST_RTI:    state_d = TMS ? ST_SEL_DR : ST_RTI;
         ST_SEL_DR: state_d = TMS ? ST_SEL_IR : ST_CAP_DR;
         ST_CAP_DR: state_d = TMS ? ST_EX1_DR : ST_SH_DR;
         ST_SH_DR:  state_d = TMS ? ST_EX1_DR : ST_SH_DR;
         ST_EX1_DR: state_d = TMS ? ST_UPD_DR : ST_PA_DR;
         ST_PA_DR:  state_d = TMS ? ST_EX2_DR : ST_PA_DR;
         ST_EX2_DR: state_d = TMS ? ST_UPD_DR : ST_SH_DR;
         ST_UPD_DR: state_d = TMS ? ST_SEL_DR : ST_RTI;
         ST_SEL_IR: state_d = TMS ? ST_TLR    : ST_CAP_IR;
         ST_CAP_IR: state_d = TMS ? ST_EX1_IR : ST_SH_IR;
         ST_SH_IR:  state_d = TMS ? ST_EX1_IR : ST_SH_IR;
         ST_EX1_IR: state_d = TMS ? ST_UPD_IR : ST_PA_IR;
         ST_PA_IR:  state_d = TMS ? ST_EX2_IR : ST_PA_IR;
         ST_EX2_IR: state_d = TMS ? ST_UPD_IR : ST_SH_IR;
         ST_UPD_IR: state_d = TMS ? ST_SEL_DR : ST_RTI;
      endcase
   end

   always_comb begin
      strobe_c        = '0;
      strobe_c.tlr    = (state_q == ST_TLR);
      strobe_c.cap_dr = (state_q == ST_CAP_DR);
      strobe_c.sh_dr  = (state_q == ST_SH_DR);
      strobe_c.upd_dr = (state_q == ST_UPD_DR);
      strobe_c.cap_ir = (state_q == ST_CAP_IR);
      strobe_c.sh_ir  = (state_q == ST_SH_IR);
      strobe_c.upd_ir = (state_q == ST_UPD_IR);
   end

endmodule

// File: rtl/tap_controller.sv
// TAP controller top: instruction register, TDO mux and state strobes.
// Define TAP_BYPASS_REG_EN to build the internal 1-bit bypass register.
module tap_controller
   import tap_pkg::*;
#(
   parameter int unsigned           IR_WIDTH   = IR_WIDTH_DEF,
   parameter logic [IR_WIDTH-1:0]   IR_RESET   = IR_WIDTH'(OP_IDCODE),
   parameter logic [IR_WIDTH-1:0]   IR_CAPTURE = IR_WIDTH'(OP_SAMPLE)
) (
   input  logic                TCK,
   input  logic                TRST,
   input  logic                TMS,
   input  logic                TDI,
   input  logic                DR_TDO,
   output logic                TDO,
   output logic                TDO_EN,
   output logic [IR_WIDTH-1:0] LATCH_JTAG_IR,
   output logic [3:0]          TAP_STATE,
   output logic                TEST_LOGIC_RESET,
   output logic                CAPTURE_DR,
   output logic                SHIFT_DR,
   output logic                UPDATE_DR,
   output logic                CAPTURE_IR,
   output logic                SHIFT_IR,
   output logic                UPDATE_IR
);

   tap_state_e          state_q;
   tap_strobe_t         strobe_c;
   logic [IR_WIDTH-1:0] ir_sh_q, ir_sh_d;
   logic [IR_WIDTH-1:0] ir_q, ir_d;
   logic                dr_tdo_c;

   tap_fsm u_fsm (
      .TCK      (TCK),
      .TRST     (TRST),
      .TMS      (TMS),
      .state_q  (state_q),
      .strobe_c (strobe_c)
   );

   // Shift stage moves only in Capture/Shift-IR; the active IR only in Update-IR or TLR.
   always_comb begin
      ir_sh_d = ir_sh_q;
      ir_d    = ir_q;
      case (state_q)
         ST_CAP_IR: ir_sh_d = IR_CAPTURE;
         ST_SH_IR:  ir_sh_d = {TDI, ir_sh_q[IR_WIDTH-1:1]};
         ST_UPD_IR: ir_d    = ir_sh_q;
         ST_TLR:    ir_d    = IR_RESET;
         default:   ;
      endcase
   end

   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         ir_sh_q <= IR_CAPTURE;
         ir_q    <= IR_RESET;
      end else begin
         ir_sh_q <= ir_sh_d;
         ir_q    <= ir_d;
      end
   end

`ifdef TAP_BYPASS_REG_EN
   logic byp_q, byp_d;

   always_comb begin
      byp_d = byp_q;
      if (strobe_c.cap_dr)     byp_d = 1'b0;
      else if (strobe_c.sh_dr) byp_d = TDI;
   end

   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) byp_q <= 1'b0;
      else      byp_q <= byp_d;
   end

   assign dr_tdo_c = (ir_q == {IR_WIDTH{1'b1}}) ? byp_q : DR_TDO;
`else
   assign dr_tdo_c = DR_TDO;
`endif

   always_comb begin
      TDO    = 1'b0;
      TDO_EN = 1'b0;
      if (strobe_c.sh_ir) begin
         TDO    = ir_sh_q[0];
         TDO_EN = 1'b1;
      end else if (strobe_c.sh_dr) begin
         TDO    = dr_tdo_c;
         TDO_EN = 1'b1;
      end
   end

   assign LATCH_JTAG_IR    = ir_q;
   assign TAP_STATE        = 4'(state_q);
   assign TEST_LOGIC_RESET = strobe_c.tlr;
   assign CAPTURE_DR       = strobe_c.cap_dr;
   assign SHIFT_DR         = strobe_c.sh_dr;
   assign UPDATE_DR        = strobe_c.upd_dr;
   assign CAPTURE_IR       = strobe_c.cap_ir;
   assign SHIFT_IR         = strobe_c.sh_ir;
   assign UPDATE_IR        = strobe_c.upd_ir;

endmodule

// File: doc/tap_controller.md
# tap_controller

IEEE 1149.1-style TAP controller that sequences the JTAG instruction path. It runs the 16-state TAP state machine from TMS, shifts and captures the 4-bit instruction register, and drives LATCH_JTAG_IR into `state_decoder`. It also emits the per-state strobes the data registers use and muxes TDO between the IR, an optional internal bypass bit, and the selected data register.

## Interface
- IR_WIDTH, 4, instruction register width; must match the decoder input.
- IR_RESET, 4'h7, value loaded into LATCH_JTAG_IR on reset and in Test-Logic-Reset (IDCODE).
- IR_CAPTURE, 4'b0001, value parallel-loaded into the IR shift stage in Capture-IR.

Ports:
- TCK  in  1  TAP clock; all state updates on the rising edge.
- TRST  in  1  asynchronous, active-high reset.
- TMS  in  1  mode select, sampled on the rising TCK edge.
- TDI  in  1  serial data in.
- DR_TDO  in  1  serial output of the data register selected by the decoder.
- TDO  out  1  serial data out.
- TDO_EN  out  1  high in Shift-IR and Shift-DR only.
- LATCH_JTAG_IR  out  IR_WIDTH  active instruction, feeds `state_decoder`.
- TAP_STATE  out  4  current state encoding.
- TEST_LOGIC_RESET, CAPTURE_DR, SHIFT_DR, UPDATE_DR, CAPTURE_IR, SHIFT_IR, UPDATE_IR  out  1 each  high while the TAP is in that state.

## Operation
- State encoding:
  - TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PA_DR=3, EX2_DR=0, UPD_DR=5
  - SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PA_IR=B, EX2_IR=8, UPD_IR=D
- Transitions (TMS=0 / TMS=1):
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - SEL_IR: CAP_IR / TLR
  - CAP_x: SH_x / EX1_x
  - SH_x: SH_x / EX1_x
  - EX1_x: PA_x / UPD_x
  - PA_x: PA_x / EX2_x
  - EX2_x: SH_x / UPD_x
  - UPD_x: RTI / SEL_DR
- Five consecutive TMS=1 edges reach TLR from any state.
- IR shift stage `ir_sh`, updated on the rising edge while in the named state:
  - CAP_IR: `ir_sh <= IR_CAPTURE`.
  - SH_IR: `ir_sh <= {TDI, ir_sh[IR_WIDTH-1:1]}`, LSB first.
  - Held in all other states.
- LATCH_JTAG_IR:
  - UPD_IR: `<= ir_sh`.
  - TLR: `<= IR_RESET`.
  - Held in all other states.
  - Never changes during a shift; the decoder sees only complete instructions.
- TDO is a combinational mux on the current state:
  - SH_IR: `ir_sh[0]`.
  - SH_DR: bypass bit or DR_TDO (see Configuration).
  - All other states: 0.
- All state strobes are combinational decodes of TAP_STATE.

## Timing
- Reset values on TRST=1:
  - TAP_STATE=F, TEST_LOGIC_RESET=1, all other strobes 0.
  - LATCH_JTAG_IR=IR_RESET, `ir_sh`=IR_CAPTURE, bypass bit 0.
  - TDO=0, TDO_EN=0.
- TRST asserted mid-shift aborts immediately. LATCH_JTAG_IR takes IR_RESET and the partial shift is discarded.
- State latency: one TCK per TMS-sampled edge. A strobe is high for exactly the cycles spent in its state.
- Shift latency:
  - IR: the bit on TDI at edge k appears on TDO IR_WIDTH edges later.
  - Bypass: one edge later.
- TDO is valid before each rising edge, from the settled current state; the bench samples just before the edge. This is a single-clock design; there is no falling-edge TDO.
- Pause states hold `ir_sh` and LATCH_JTAG_IR indefinitely.
- EX2→SH resumes the shift with no lost bit.
- Update only in UPD_IR. Passing CAP_IR→EX1_IR→UPD_IR with zero shifts latches IR_CAPTURE.

## Configuration
- TAP_BYPASS_REG_EN defined:
  - Internal 1-bit bypass register, cleared in CAP_DR, `<= TDI` in SH_DR.
  - In SH_DR, TDO = bypass bit when LATCH_JTAG_IR == 4'hF, else DR_TDO.
- TAP_BYPASS_REG_EN undefined:
  - No bypass flop.
  - In SH_DR, TDO = DR_TDO for every instruction; BYPASS is implemented externally.

## Structure
- Package `tap_pkg`:
  - State encoding constants.
  - Instruction opcodes: IDCODE 7, BYPASS F, SAMPLE 1, EXTEST 2, INTEST 3, RUNBIST 4, USERCODE 8.
  - IR_WIDTH default.
- Optional sub-module `tap_fsm`: state register, next-state logic and strobe decode. Top level holds the IR, bypass bit and TDO mux.

## Test plan
- TRST pulse in SH_IR with `ir_sh` partially shifted → TAP_STATE=F, LATCH_JTAG_IR=7, TDO_EN=0 during reset.
- From SH_DR apply TMS=1 ×5 → TAP_STATE reaches F on the 5th edge and LATCH_JTAG_IR reloads 7.
- From RTI:
  - TMS 1,1,0,0 → SH_IR.
  - Shift TDI 1,1,1,1 with TMS 0,0,0,1 (last bit on EX1 entry).
  - TMS 1 → UPD_IR.
  - Expect: TDO out 1,0,0,0; LATCH_JTAG_IR=F after UPD_IR, unchanged before it.
- Pause-IR mid-shift: shift 2 bits, hold PA_IR for 10 cycles, resume via EX2_IR → final LATCH equals uninterrupted result; LATCH stable throughout.
- TAP_BYPASS_REG_EN, IR=F:
  - Shift TDI 1,0,1,1 in SH_DR → TDO 0,1,0,1.
  - Repeat without the macro → TDO follows DR_TDO.
- CAP_IR→EX1_IR→UPD_IR with no shift → LATCH_JTAG_IR=1 (SAMPLE).
